// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared control-bundle layout, bubble and forwarding encodings
// Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int CTRL_W     = 10;

   // Bundle layout {jump[1:0], branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
   localparam int CTRL_REG_WRITE  = 0;
   localparam int CTRL_ALU_SRC    = 1;
   localparam int CTRL_MEM_WRITE  = 2;
   localparam int CTRL_ALU_OP_LO  = 3;
   localparam int CTRL_ALU_OP_HI  = 4;
   localparam int CTRL_MEM_TO_REG = 5;
   localparam int CTRL_MEM_READ   = 6;
   localparam int CTRL_BRANCH     = 7;
   localparam int CTRL_JUMP_LO    = 8;
   localparam int CTRL_JUMP_HI    = 9;

   typedef logic [CTRL_W-1:0]     ctrl_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [1:0]            fwd_t;

   typedef struct packed {
      ctrl_t     ctrl;
      reg_addr_t rd;
      reg_addr_t rs1;
      reg_addr_t rs2;
   } stage_t;

   localparam stage_t BUBBLE = '0;

   localparam fwd_t FWD_REG = 2'b00;
   localparam fwd_t FWD_MEM = 2'b10;
   localparam fwd_t FWD_WB  = 2'b01;

   // Youngest producer wins; x0 is hard-wired zero and never forwarded.
   function automatic fwd_t fwd_sel(input logic      mem_wr,
                                    input reg_addr_t mem_rd,
                                    input logic      wb_wr,
                                    input reg_addr_t wb_rd,
                                    input reg_addr_t src);
      if (mem_wr && (mem_rd != '0) && (mem_rd == src))
         return FWD_MEM;
      else if (wb_wr && (wb_rd != '0) && (wb_rd == src))
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// ============================================================================
// hazard_fwd_unit : combinational load-use stall, redirect flush, EX forwarding
// Revision        : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit
   import ctrl_pkg::*;
(
   input  logic      reset,
   input  logic      id_valid,
   input  reg_addr_t id_rs1,
   input  reg_addr_t id_rs2,
   input  logic      id_use_rs1,
   input  logic      id_use_rs2,
   input  logic      ex_redirect,
   input  logic      ex_mem_read,
   input  reg_addr_t ex_rd,
   input  reg_addr_t ex_rs1,
   input  reg_addr_t ex_rs2,
   input  logic      mem_reg_write,
   input  reg_addr_t mem_rd,
   input  logic      wb_reg_write,
   input  reg_addr_t wb_rd,
   output logic      stall,
   output logic      flush,
   output logic      pc_write,
   output logic      if_id_write,
   output logic      if_id_flush,
   output fwd_t      forward_a,
   output fwd_t      forward_b
);

   logic rs_hit;

   always_comb begin
      rs_hit = (id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd));
      stall  = !reset && id_valid && ex_mem_read && (ex_rd != '0) && rs_hit;
      flush  = !reset && ex_redirect;

      // A redirect discards the stalled wrong-path ID instruction, so it overrides the stall.
      pc_write    = !reset && (flush || !stall);
      if_id_write = !reset && (flush || !stall);
      if_id_flush = flush;

      forward_a = FWD_REG;
      forward_b = FWD_REG;
      if (!reset) begin
         forward_a = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rs1);
         forward_b = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rs2);
      end
   end

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe.sv
// ============================================================================
// ctrl_pipe : carries the decoded control bundle through EX/MEM/WB registers
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ctrl_pipe
   import ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  ex_redirect,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [CTRL_W-1:0]     mem_ctrl,
   output logic [CTRL_W-1:0]     wb_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b
);

   stage_t ex_stage;
   stage_t mem_stage;
   stage_t wb_stage;
   stage_t id_stage;
   logic   stall;
   logic   flush;
   logic   ex_take;

   hazard_fwd_unit u_hazard_fwd (
      .reset         (reset),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .ex_redirect   (ex_redirect),
      .ex_mem_read   (ex_stage.ctrl[CTRL_MEM_READ]),
      .ex_rd         (ex_stage.rd),
      .ex_rs1        (ex_stage.rs1),
      .ex_rs2        (ex_stage.rs2),
      .mem_reg_write (mem_stage.ctrl[CTRL_REG_WRITE]),
      .mem_rd        (mem_stage.rd),
      .wb_reg_write  (wb_stage.ctrl[CTRL_REG_WRITE]),
      .wb_rd         (wb_stage.rd),
      .stall         (stall),
      .flush         (flush),
      .pc_write      (pc_write),
      .if_id_write   (if_id_write),
      .if_id_flush   (if_id_flush),
      .forward_a     (forward_a),
      .forward_b     (forward_b)
   );

   assign id_stage = '{ctrl: id_ctrl, rd: id_rd, rs1: id_rs1, rs2: id_rs2};
   assign ex_take  = id_valid && !stall && !flush;

   // EX/MEM/WB never stall; only the EX input is replaced by a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_stage  <= BUBBLE;
         mem_stage <= BUBBLE;
         wb_stage  <= BUBBLE;
      end else begin
         ex_stage  <= ex_take ? id_stage : BUBBLE;
         mem_stage <= ex_stage;
         wb_stage  <= mem_stage;
      end
   end

   assign ex_ctrl  = ex_stage.ctrl;
   assign ex_rd    = ex_stage.rd;
   assign ex_rs1   = ex_stage.rs1;
   assign ex_rs2   = ex_stage.rs2;
   assign mem_ctrl = mem_stage.ctrl;
   assign mem_rd   = mem_stage.rd;
   assign wb_ctrl  = wb_stage.ctrl;
   assign wb_rd    = wb_stage.rd;

endmodule

`default_nettype wire

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Receives the decoded control bundle from the main control decoder in ID and carries it through the EX, MEM and WB pipeline registers.
Detects load-use hazards and inserts bubbles. Applies flushes on EX redirects (taken branch, JAL, JALR).
Generates the EX-stage operand forwarding selects. It sits between the control decoder and the 5-stage datapath, and all datapath muxes/enables downstream of ID read their control from here.

Parameters:
REG_ADDR_W, 5, register index width
CTRL_W, 10, bundle width {jump[1:0], branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_ctrl  in  CTRL_W  control bundle from the decoder for the ID instruction
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  ID register indices
id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
ex_redirect  in  1  EX resolved a taken branch or jump this cycle
ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W each  registered bundles per stage
ex_rd, mem_rd, wb_rd  out  REG_ADDR_W each  registered destination indices
ex_rs1, ex_rs2  out  REG_ADDR_W each  registered EX source indices
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  clear IF/ID to a bubble
forward_a, forward_b  out  2 each  EX operand select: 00 regfile, 10 MEM result, 01 WB result

Behaviour:
- Bubble definition: ctrl = 0, rd = rs1 = rs2 = 0.
- Reset: every stage register is set to a bubble on the clock edge where reset=1.
- While reset=1: pc_write = if_id_write = if_id_flush = 0 and forward_a = forward_b = 00.
- Stage advance: all stage registers update every cycle; no global stall of EX/MEM/WB.
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID bundle, or a bubble (rules below).
- ID bundle is treated as a bubble when id_valid = 0.
- Load-use stall is combinational and asserted when all hold:
  - ex_ctrl.mem_read = 1 and ex_rd != 0;
  - (id_use_rs1 and id_rs1 == ex_rd) or (id_use_rs2 and id_rs2 == ex_rd);
  - id_valid = 1.
- On stall: pc_write = 0, if_id_write = 0, EX <= bubble next edge. This gives exactly one bubble per load-use; the following cycle re-evaluates with the load now in MEM.
- On flush (ex_redirect = 1):
  - if_id_flush = 1, EX <= bubble;
  - pc_write = 1, if_id_write = 1 (redirect target is fetched).
- Simultaneous stall and flush: flush wins. The stalled ID instruction is on the wrong path and is discarded; pc_write = 1.
- Otherwise: pc_write = if_id_write = 1, if_id_flush = 0.
- Forwarding (combinational, per operand; shown for A/ex_rs1, B identical with ex_rs2):
  - 10 if mem_ctrl.reg_write and mem_rd != 0 and mem_rd == ex_rs1;
  - else 01 if wb_ctrl.reg_write and wb_rd != 0 and wb_rd == ex_rs1;
  - else 00.
  - MEM beats WB when both match. x0 is never forwarded.
- MEM-stage mem_to_reg forwarding from a load is never needed, because the load-use stall guarantees a one-cycle gap.
- No X propagation: any X bits arriving in id_ctrl are registered as-is. Only reset and bubbles drive defined zeros.

Decomposition:
- Shared package ctrl_pkg holds:
  - CTRL_W and bit-index constants for each bundle field;
  - the bubble constant;
  - FWD_REG = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01.
- The control decoder and datapath import the same package.
- One natural sub-module: hazard_fwd_unit, purely combinational. It produces stall, the flush-derived enables, and forward_a/b. The pipeline registers remain in ctrl_pipe.

Test Plan:
- Reset held 2 cycles with id_ctrl = 10'b00_011_00_011 (load) -> ex/mem/wb_ctrl all 0 and pc_write = 0 during reset; first post-reset edge gives ex_ctrl = 10'b00_011_00_011.
- Load x5 in ID, then R-type using rs1 = 5 -> one cycle with pc_write = 0, if_id_write = 0, then ex_ctrl = 0 for that cycle; next cycle the R-type enters EX with forward_a = 01 (load in WB).
- R-type writes x7, next R-type reads rs2 = 7 -> forward_b = 10. Same sequence with x0 -> forward_b = 00.
- ex_redirect = 1 while ID holds a load-use pair -> if_id_flush = 1, pc_write = 1, EX bubble next edge, no stall cycle.
- id_valid = 0 with nonzero id_ctrl -> EX captures bubble; a load in EX with matching rs1 and id_use_rs1 = 0 -> no stall.
